// File: rtl/hex_display_ctrl_if.sv
// rtl/hex_display_ctrl_if.sv - write handshake and status bundle for hex_display_ctrl
interface hex_display_ctrl_if;
  logic        wr_valid;
  logic [23:0] wr_data;
  logic        wr_blank_lz;
  logic        wr_ready;
  logic        busy;

  modport master (
    output wr_valid, wr_data, wr_blank_lz,
    input  wr_ready, busy
  );

  modport slave (
    input  wr_valid, wr_data, wr_blank_lz,
    output wr_ready, busy
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - six-digit hex display driver scanning one shared seven-segment decoder
module seven_segment (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  // active-low, bit0 = top segment, bit6 = middle segment
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end
endmodule

module hex_display_ctrl (
  input  logic                     clk,
  input  logic                     rst_n,
  hex_display_ctrl_if.slave        bus,
  output logic [6:0]               HEX0,
  output logic [6:0]               HEX1,
  output logic [6:0]               HEX2,
  output logic [6:0]               HEX3,
  output logic [6:0]               HEX4,
  output logic [6:0]               HEX5
);
  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx;
  logic [23:0] shadow_data;
  logic        shadow_blank;
  logic        seen_nz;
  logic [6:0]  hex_q [6];
  logic        accept;
  logic [3:0]  nibble;
  logic [6:0]  seg;
  logic [6:0]  seg_final;

  assign nibble = shadow_data[{idx, 2'b00} +: 4];

  seven_segment u_dec (
    .nibble (nibble),
    .seg    (seg)
  );

  // digit 0 is exempt so an all-zero value still shows a single "0"
  assign seg_final = (shadow_blank && nibble == 4'h0 && !seen_nz && idx != 3'd0)
                     ? 7'h7F : seg;

  assign bus.wr_ready = (state == IDLE);
  assign bus.busy     = (state == SCAN);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.wr_valid) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (idx == 3'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= 3'd5;
      seen_nz      <= 1'b0;
      shadow_data  <= 24'h0;
      shadow_blank <= 1'b0;
      for (int i = 0; i < 6; i++) hex_q[i] <= 7'h7F;
    end else if (accept) begin
      shadow_data  <= bus.wr_data;
      shadow_blank <= bus.wr_blank_lz;
      idx          <= 3'd5;
      seen_nz      <= 1'b0;
    end else if (state == SCAN) begin
      for (int i = 0; i < 6; i++) begin
        if (idx == 3'(i)) hex_q[i] <= seg_final;
      end
      if (nibble != 4'h0) seen_nz <= 1'b1;
      idx <= (idx == 3'd0) ? 3'd5 : idx - 3'd1;
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - directed and randomized bench for hex_display_ctrl
module tb_hex_display_ctrl;
  logic       clk;
  logic       rst_n;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  int         passed;
  int         total;
  logic [6:0] shown [6];

  hex_display_ctrl_if bus ();

  hex_display_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .HEX0  (HEX0),
    .HEX1  (HEX1),
    .HEX2  (HEX2),
    .HEX3  (HEX3),
    .HEX4  (HEX4),
    .HEX5  (HEX5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // a digit is blank when blanking is requested and it and every higher digit are zero
  function automatic logic [6:0] model_digit(input logic [23:0] v, input logic bl, input int n);
    logic [23:0] upper;
    upper = v >> (4 * n);
    if (bl && n != 0 && upper == 24'h0) return 7'h7F;
    return seg_of(upper[3:0]);
  endfunction

  function automatic logic [6:0] hex_at(input int n);
    case (n)
      0: return HEX0;  1: return HEX1;  2: return HEX2;
      3: return HEX3;  4: return HEX4;  default: return HEX5;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic chk_all_shown(input string tag);
    for (int n = 0; n < 6; n++) chk($sformatf("%s_hex%0d", tag, n), 32'(hex_at(n)), 32'(shown[n]));
  endtask

  // presents a value and returns after the #1 following the accepting edge
  task automatic do_accept(input logic [23:0] v, input logic bl);
    bit ok;
    ok = 0;
    @(negedge clk);
    bus.wr_valid    = 1'b1;
    bus.wr_data     = v;
    bus.wr_blank_lz = bl;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = bus.wr_ready;
      @(posedge clk);
      #1;
      if (!ok) @(negedge clk);
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  // checks the six scan edges following an accept, including held digits
  task automatic scan_check(input string tag, input logic [23:0] v, input logic bl);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      shown[6 - k] = model_digit(v, bl, 6 - k);
      chk_all_shown($sformatf("%s_t%0d", tag, k));
      chk($sformatf("%s_ready_t%0d", tag, k), 32'(bus.wr_ready), (k == 6) ? 32'd1 : 32'd0);
      chk($sformatf("%s_busy_t%0d", tag, k), 32'(bus.busy), (k == 6) ? 32'd0 : 32'd1);
    end
  endtask

  task automatic write_and_check(input string tag, input logic [23:0] v, input logic bl);
    do_accept(v, bl);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    scan_check(tag, v, bl);
  endtask

  initial begin
    logic [23:0] rv;
    logic        rb;
    passed = 0;
    total  = 0;
    bus.wr_valid    = 1'b0;
    bus.wr_data     = 24'h0;
    bus.wr_blank_lz = 1'b0;
    rst_n = 1'b0;
    for (int n = 0; n < 6; n++) shown[n] = 7'h7F;

    // reset state, with a write offered that must be ignored
    bus.wr_valid = 1'b1;
    bus.wr_data  = 24'hABCDEF;
    repeat (3) @(posedge clk);
    #1;
    chk_all_shown("reset");
    chk("reset_ready", 32'(bus.wr_ready), 32'd1);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk_all_shown("idle");

    write_and_check("w123456", 24'h123456, 1'b0);
    chk("lit_hex5", 32'(HEX5), 32'(7'b1111001));
    chk("lit_hex0", 32'(HEX0), 32'(7'b0000010));
    write_and_check("w0000a5", 24'h0000A5, 1'b1);
    chk("lit_a5_hex1", 32'(HEX1), 32'(7'b0001000));
    write_and_check("wzero_bl", 24'h000000, 1'b1);
    chk("lit_zero_hex0", 32'(HEX0), 32'(7'b1000000));
    write_and_check("wzero_nb", 24'h000000, 1'b0);
    write_and_check("w100000", 24'h100000, 1'b1);
    chk("lit_100000_hex2", 32'(HEX2), 32'(7'b1000000));

    // second value held during the scan is taken at T+7
    do_accept(24'h789ABC, 1'b0);
    @(negedge clk);
    bus.wr_data     = 24'h00F00D;
    bus.wr_blank_lz = 1'b1;
    scan_check("hold_first", 24'h789ABC, 1'b0);
    @(posedge clk);
    #1;
    chk("hold_accept_t7", 32'(bus.busy), 32'd1);
    chk_all_shown("hold_t7");
    @(negedge clk);
    bus.wr_valid = 1'b0;
    scan_check("hold_second", 24'h00F00D, 1'b1);

    // reset after T+3 aborts the scan
    do_accept(24'h654321, 1'b0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      shown[6 - k] = model_digit(24'h654321, 1'b0, 6 - k);
    end
    chk_all_shown("pre_abort");
    rst_n = 1'b0;
    #1;
    for (int n = 0; n < 6; n++) shown[n] = 7'h7F;
    chk_all_shown("abort");
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_ready", 32'(bus.wr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_abort_busy", 32'(bus.busy), 32'd0);
    chk_all_shown("post_abort");
    write_and_check("after_abort", 24'h0BEEF0, 1'b1);

    for (int r = 0; r < 20; r++) begin
      rv = 24'($urandom) >> (4 * $urandom_range(0, 6));
      rb = 1'($urandom);
      write_and_check($sformatf("rand%0d", r), rv, rb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert and active-low.
REQ-003 The block SHALL have port wr_valid, input, 1 bit: requester offers a new display value.
REQ-004 The block SHALL have port wr_data, input, 24 bits: six hex nibbles, nibble n (bits 4n+3:4n) maps to digit n.
REQ-005 The block SHALL have port wr_blank_lz, input, 1 bit: leading-zero blanking request, qualified by wr_valid.
REQ-006 The block SHALL have port wr_ready, output, 1 bit: block can accept a write.
REQ-007 The block SHALL have port busy, output, 1 bit: scan in progress.
REQ-008 The block SHALL have ports HEX0..HEX5, output, 7 bits each: active-low segments, bit0 = top segment, bit6 = middle segment.

Function
REQ-009 The block SHALL contain exactly one seven_segment decoder instance, time-shared across all six digits.
REQ-010 The FSM SHALL have two states: IDLE and SCAN.
REQ-011 wr_ready SHALL equal 1 in IDLE and 0 in SCAN, decoded from state only, with no combinational path from wr_valid.
REQ-012 A write SHALL be accepted on a rising edge where wr_valid=1 and wr_ready=1.
REQ-013 On an accepted write, the block SHALL latch wr_data and wr_blank_lz into shadow registers, set digit index idx=5, clear seen_nz, and enter SCAN.
REQ-014 wr_valid while in SCAN SHALL be ignored; the requester holds wr_valid and wr_data until accepted.
REQ-015 In SCAN, at each edge, the block SHALL feed shadow nibble idx to the shared decoder and register the result into HEX[idx].
REQ-016 After each SCAN edge, idx SHALL decrement; on the edge that writes HEX0, the FSM SHALL return to IDLE.
REQ-017 Timing: a write accepted at edge T SHALL update HEX5 at T+1, HEX4 at T+2, and so on, with HEX0 at T+6.
REQ-018 wr_ready SHALL be 1 again after edge T+6, so the earliest next accept is edge T+7.
REQ-019 Leading-zero blanking: if shadow blank_lz=1, the nibble is 0, seen_nz=0, and idx!=0, then HEX[idx] SHALL receive 7'h7F instead of the decoded value.
REQ-020 seen_nz SHALL be set on the first nonzero nibble scanned and SHALL stay set until the next accept.
REQ-021 Digit 0 SHALL never be blanked, so value 0 with blank_lz=1 displays "0" on HEX0 and blanks HEX1..HEX5.
REQ-022 Each HEXn SHALL hold its value between scans and change only on its own scan edge; a partial display mid-scan is permitted.
REQ-023 busy SHALL equal 1 in SCAN and 0 in IDLE.

Reset
REQ-024 While rst_n=0, the block SHALL force HEX0..HEX5=7'h7F, state=IDLE, idx=5, seen_nz=0, and clear the shadow registers.
REQ-025 During reset, wr_ready SHALL be 1 and busy SHALL be 0.
REQ-026 An rst_n assertion mid-SCAN SHALL abort the scan immediately, with no further HEX updates; after release, the block SHALL wait in IDLE for a new write.
REQ-027 No write SHALL be accepted on an edge where rst_n=0.

Verification
REQ-028 Scenario: reset, then write 24'h123456 with blank_lz=0 -> HEX5..HEX0 = 7'b1111001, 0100100, 0110000, 0011001, 0010010, 0000010 at T+1..T+6; wr_ready=0 for T+1..T+6.
REQ-029 Scenario: write 24'h0000A5 with blank_lz=1 -> HEX5..HEX2=7'h7F, HEX1=7'b0001000, HEX0=7'b0010010.
REQ-030 Scenario: write 24'h000000 with blank_lz=1 -> HEX5..HEX1=7'h7F and HEX0=7'b1000000; write 24'h000000 with blank_lz=0 -> all six digits=7'b1000000.
REQ-031 Scenario: write 24'h100000 with blank_lz=1 -> no digit blanked, interior zeros shown as 7'b1000000.
REQ-032 Scenario: hold wr_valid with a new value during SCAN -> not accepted until edge T+7; the first value completes unaltered on all digits.
REQ-033 Scenario: assert rst_n low after edge T+3 of a scan -> all HEX read 7'h7F immediately, busy=0; a write after release completes normally.
